// File: rtl/input_debouncer_pkg.sv
// Shared constants for the board-input debouncer: clock rate, debounce window and KEY/SW bit layout.
package input_debouncer_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    localparam int KEY_W   = 2;
    localparam int SW_W    = 10;
    localparam int KEY_LSB = 0;
    localparam int SW_LSB  = 2;

    // KEYs are active-low on the board, so they are inverted after synchronization
    localparam logic [KEY_W+SW_W-1:0] INVERT_MASK_DEFAULT = 12'h003;

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One input bit: synchronizer, optional inversion, hold-time counter filter and edge pulses.
module debounce_bit #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter logic INVERT          = 1'b0,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic                   stable_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   differs;
    logic                   accept;

    assign differs = (s_q != stable_q);
    assign accept  = differs && (cnt_q == CNT_LAST);
    assign db      = stable_q;

    // Synchronizer flops reset to the raw-pin equivalent of RESET_VAL so the
    // filter sees no apparent change as reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL ^ INVERT}};
            s_q      <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            s_q    <= sync_q[SYNC_STAGES-1] ^ INVERT;
            rise   <= accept && s_q;
            fall   <= accept && !s_q;
            if (accept) begin
                stable_q <= s_q;
                cnt_q    <= '0;
            end else if (differs) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces the DE10-Lite KEY/SW inputs ahead of the PIO export ports.
// Define INPUT_DEBOUNCER_EDGE_LATCH_EN to add sticky rise flags with per-bit clear.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int               WIDTH           = KEY_W + SW_W,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int               CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter logic [WIDTH-1:0] INVERT_MASK     = INVERT_MASK_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    input  logic [WIDTH-1:0] evt_clear,
    output logic [WIDTH-1:0] evt_flags
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .INVERT         (INVERT_MASK[gi]),
            .RESET_VAL      (RESET_VAL[gi])
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_in[gi]),
            .db   (db_out[gi]),
            .rise (rise_pulse[gi]),
            .fall (fall_pulse[gi])
        );
    end

`ifdef INPUT_DEBOUNCER_EDGE_LATCH_EN
    // A new rise takes priority over a clear arriving in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_flags <= '0;
        end else begin
            evt_flags <= rise_pulse | (evt_flags & ~evt_clear);
        end
    end
`else
    logic unused_evt_clear;
    assign unused_evt_clear = ^evt_clear;
    assign evt_flags        = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: a sliding-window reference model predicts every cycle.
module tb_input_debouncer;

    localparam int W    = 12;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int PIPE = S + 1;
    localparam int MAXE = 4000;
    localparam logic [W-1:0] INV = 12'h003;
    localparam logic [W-1:0] RV  = 12'h000;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] evt_clear;
    logic [W-1:0] db_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] evt_flags;

    input_debouncer #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .INVERT_MASK    (INV),
        .RESET_VAL      (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .db_out    (db_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .evt_clear (evt_clear),
        .evt_flags (evt_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] flags;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rise5_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the filter input at edge n is the raw level sampled PIPE
    // edges earlier (or the reset level if a reset fell inside that span); a bit
    // accepts its new level when the last D filter inputs since the previous
    // acceptance or reset all disagree with the current stable level.
    logic [W-1:0] raw_hist[MAXE];
    bit           rst_hist[MAXE];
    int           edge_n = 0;
    int           last_break[W];
    logic [W-1:0] m_stable = RV;
    logic [W-1:0] m_rise   = '0;
    logic [W-1:0] m_fall   = '0;
    logic [W-1:0] m_flags  = '0;

    initial for (int b = 0; b < W; b++) last_break[b] = -1;

    function automatic logic filt(input int n, input int b);
        if (n < PIPE) return RV[b];
        for (int j = n - PIPE; j < n; j++)
            if (rst_hist[j]) return RV[b];
        return raw_hist[n-PIPE][b] ^ INV[b];
    endfunction

    always @(posedge clk) begin
        logic ok;
        raw_hist[edge_n] = raw_in;
        rst_hist[edge_n] = reset;
        if (reset) begin
            m_stable = RV;
            m_rise   = '0;
            m_fall   = '0;
            m_flags  = '0;
            for (int b = 0; b < W; b++) last_break[b] = edge_n;
        end else begin
`ifdef INPUT_DEBOUNCER_EDGE_LATCH_EN
            m_flags = m_rise | (m_flags & ~evt_clear);
`else
            m_flags = '0;
`endif
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                ok = 1'b1;
                for (int k = 0; k < D; k++) begin
                    if (edge_n - k <= last_break[b]) ok = 1'b0;
                    else if (filt(edge_n - k, b) == m_stable[b]) ok = 1'b0;
                end
                if (ok) begin
                    m_stable[b]   = ~m_stable[b];
                    m_rise[b]     = m_stable[b];
                    m_fall[b]     = ~m_stable[b];
                    last_break[b] = edge_n;
                end
            end
        end
        sb_q.push_back('{db: m_stable, rise: m_rise, fall: m_fall, flags: m_flags});
        if (edge_n < MAXE - 1) edge_n++;
    end

    // Monitor: outputs are presented every cycle, compared half a cycle after the edge
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("db_out", 32'(db_out), 32'(e.db));
            checkOutput("rise_pulse", 32'(rise_pulse), 32'(e.rise));
            checkOutput("fall_pulse", 32'(fall_pulse), 32'(e.fall));
            checkOutput("evt_flags", 32'(evt_flags), 32'(e.flags));
            if (rise_pulse[5] === 1'b1) rise5_count++;
        end
    end

    task automatic applyStimulus(input logic [W-1:0] r, input logic [W-1:0] c, input int cycles);
        raw_in    = r;
        evt_clear = c;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [W-1:0] r;
        raw_in    = 12'h003;
        evt_clear = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_db", 32'(db_out), 32'(RV));
        applyStimulus(12'h003, '0, 10);

        $display("[TB] clean step on SW2");
        applyStimulus(12'h013, '0, 10);
        applyStimulus(12'h003, '0, 10);

        $display("[TB] glitch on SW2");
        applyStimulus(12'h013, '0, 3);
        applyStimulus(12'h003, '0, 10);

        $display("[TB] bounce on SW3");
        rise5_count = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(12'h023, '0, 2);
            applyStimulus(12'h003, '0, 2);
        end
        applyStimulus(12'h023, '0, 12);
        checkOutput("bounce_rise5_count", 32'(rise5_count), 32'd1);

        $display("[TB] KEY0 press and release");
        applyStimulus(12'h022, '0, 10);
        applyStimulus(12'h023, '0, 10);

        $display("[TB] sticky flags on bit 3");
        r = 12'h02b;
        applyStimulus(r, '0, 10);
        applyStimulus(r, 12'h008, 1);
        applyStimulus(r, '0, 3);
        applyStimulus(12'h023, '0, 10);
        applyStimulus(r, '0, 6);
        applyStimulus(r, 12'h008, 1);
        applyStimulus(r, '0, 4);

        $display("[TB] reset mid-count");
        applyStimulus(r | 12'h040, '0, 5);
        reset = 1'b1;
        applyStimulus(12'h003, '0, 1);
        reset = 1'b0;
        checkOutput("midcount_reset_db", 32'(db_out), 32'(RV));
        applyStimulus(12'h003, '0, 10);

        $display("[TB] randomized traffic");
        r = 12'h003;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            applyStimulus(r, ($urandom_range(0, 3) == 0) ? W'($urandom) : '0, 1);
            if (i == 400) begin
                reset = 1'b1;
                applyStimulus(r, '0, 2);
                reset = 1'b0;
            end
        end
        applyStimulus(r, '0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions raw board inputs before they reach the system's `pushbuttons_export` and `slider_switches_export` PIO ports.
- Covers the DE10-Lite KEY[1:0] and SW[9:0].
- Per bit: multi-flop synchronizer, then a counter-based debounce filter.
- Outputs clean debounced levels plus one-cycle rise/fall pulses.
- Sits in the top level, directly upstream of the Computer_System instance.

Parameters:
- WIDTH, 12, number of input bits (bits [1:0] = KEY, bits [11:2] = SW).
- SYNC_STAGES, 2, synchronizer depth; legal range 2..4.
- DEBOUNCE_CYCLES, 500000, cycles a new level must be held before acceptance (10 ms at 50 MHz); legal range ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), per-bit counter width.
- INVERT_MASK, 12'h003, a 1 inverts that bit after synchronization (KEYs are active-low).
- RESET_VAL, 12'h000, post-inversion value loaded into synchronizer and stable state on reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- raw_in  in  WIDTH  asynchronous pin levels.
- db_out  out  WIDTH  debounced, post-inversion levels; drives the PIO export ports.
- rise_pulse  out  WIDTH  one-cycle pulse when db_out bit goes 0→1.
- fall_pulse  out  WIDTH  one-cycle pulse when db_out bit goes 1→0.
- evt_clear  in  WIDTH  clears sticky flags (used only with EDGE_LATCH_EN; ignored otherwise).
- evt_flags  out  WIDTH  sticky rise flags (driven 0 without EDGE_LATCH_EN).

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- On reset:
  - all synchronizer flops and the stable register load RESET_VAL;
  - counters load 0;
  - rise_pulse = fall_pulse = 0;
  - evt_flags = 0.
- Reset asserted mid-count discards the count; no pulse is produced.
- Synchronizer: a SYNC_STAGES-deep shift register per bit. Inversion (XOR with INVERT_MASK) is applied at its output, giving s[i].
- Per-bit filter, two states, held implicitly by counter value:
  - IDLE (s==stable, cnt==0): stays IDLE.
  - COUNT (s!=stable):
    - cnt increments by 1 each cycle while s!=stable;
    - any cycle with s==stable returns cnt to 0 (glitch rejected);
    - when s!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s, cnt<=0, and the matching pulse registers to 1 on the same edge.
- Pulses are registered and high for exactly one cycle, coincident with the db_out change.
- db_out = stable, registered.
- Latency: a clean raw step sampled at edge 0 is visible on db_out after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES=1: the level is accepted on the first cycle s differs.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- Bits are fully independent. Simultaneous changes on several bits give simultaneous pulses.
- rise_pulse and fall_pulse are never both high on the same bit.
- No combinational path from raw_in to any output.

Optional Feature:
- Macro: INPUT_DEBOUNCER_EDGE_LATCH_EN.
- Defined:
  - evt_flags[i] sets when rise_pulse[i] is 1;
  - evt_flags[i] clears when evt_clear[i] is 1 and rise_pulse[i] is 0;
  - set wins over clear in the same cycle;
  - evt_flags resets to 0.
- Undefined: no flag registers are generated, evt_flags is tied to 0, and evt_clear is unused.

Decomposition:
- Package input_debouncer_pkg holds:
  - CLK_HZ (50_000_000);
  - DEBOUNCE_MS (10);
  - derived DEBOUNCE_CYCLES_DEFAULT;
  - KEY_W (2), SW_W (10), KEY_LSB (0), SW_LSB (2);
  - default INVERT_MASK constant.
- Sub-module debounce_bit: one-bit synchronizer, inversion, counter and pulse generation. It is instantiated WIDTH times in a generate loop.
- The top level holds only the generate loop and the optional flag logic.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=12, defaults otherwise):
1. Reset: raw_in=12'h003 (KEYs released), reset high 3 cycles → db_out=0, rise/fall=0, evt_flags=0. Holding after release produces no pulse.
2. Clean step on raw_in[4] (SW2) 0→1, sampled at edge 0 → db_out[4]=1 after edge 6. rise_pulse[4]=1 for exactly that cycle; fall_pulse stays 0.
3. Glitch: raw_in[4] high for 3 cycles then low → db_out[4] and all pulses stay 0 throughout.
4. Bounce: raw_in[5] toggles every 2 cycles for 10 cycles, then holds 1 → exactly one rise_pulse[5], 6 cycles after the final transition.
5. Inversion: raw_in[0] (KEY0) 1→0 → db_out[0] rises and rise_pulse[0] fires after 6 cycles. Release 0→1 → fall_pulse[0] after 6 cycles.
6. With INPUT_DEBOUNCER_EDGE_LATCH_EN:
   - a rise on bit 3 sets evt_flags[3];
   - evt_clear[3] pulsed alone → flag 0 next cycle;
   - evt_clear[3] asserted in the same cycle as a new rise_pulse[3] → flag remains 1;
   - reset asserted at counter value 2 → no pulse, db_out=RESET_VAL.
